// File: rtl/eb_downsizer.sv
// ============================================================================
// Module   : eb_downsizer
// Brief    : Elastic width downsizer, one DWIDTH word split into up to RATIO
//            OW-bit beats with packet-last propagation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eb_downsizer #(
  parameter  int DWIDTH = 32,
  parameter  int RATIO  = 4,
  localparam int OW     = DWIDTH / RATIO,
  localparam int CW     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic [DWIDTH-1:0] t_data,
  input  logic [CW-1:0]     t_cnt,
  input  logic              t_last,
  input  logic              t_valid,
  output logic              t_ready,
  output logic [OW-1:0]     i_data,
  output logic              i_last,
  output logic              i_valid,
  input  logic              i_ready
);

  localparam logic [CW-1:0] C_MAX_IDX = CW'(RATIO - 1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  state_t            r_state;
  logic [DWIDTH-1:0] r_hold;
  logic [CW-1:0]     r_n;
  logic [CW-1:0]     r_b;
  logic              r_lst;

  logic              w_last_beat;
  logic              w_accept;
  logic              w_xfer;
  logic [CW-1:0]     w_cnt;
  logic [OW-1:0]     w_beat [RATIO];

  genvar k;
  generate
    for (k = 0; k < RATIO; k++) begin : g_beat
      assign w_beat[k] = r_hold[k*OW +: OW];
    end
  endgenerate

  assign w_last_beat = (r_b == r_n);
  assign i_valid     = (r_state == BUSY);
  assign i_last      = i_valid & r_lst & w_last_beat;
  assign i_data      = w_beat[r_b];
  // A new word may enter in the same cycle the final beat leaves.
  assign t_ready     = (r_state == EMPTY) | (i_ready & w_last_beat);
  assign w_accept    = t_valid & t_ready;
  assign w_xfer      = i_valid & i_ready;
  assign w_cnt       = (t_cnt > C_MAX_IDX) ? C_MAX_IDX : t_cnt;

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      r_state <= EMPTY;
      r_hold  <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_lst   <= 1'b0;
    end else if (w_accept) begin
      r_state <= BUSY;
      r_hold  <= t_data;
      r_n     <= w_cnt;
      r_b     <= '0;
      r_lst   <= t_last;
    end else if (w_xfer) begin
      if (w_last_beat) begin
        r_state <= EMPTY;
      end else begin
        r_b <= r_b + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eb_downsizer.sv
// ============================================================================
// Module   : tb_eb_downsizer
// Brief    : Scoreboard bench for eb_downsizer (32/4 main instance, 24/3 clamp).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_eb_downsizer;

  logic        clk = 1'b0;
  logic        rstf = 1'b0;
  logic [31:0] t_data = '0;
  logic [1:0]  t_cnt = '0;
  logic        t_last = 1'b0;
  logic        t_valid = 1'b0;
  logic        t_ready;
  logic [7:0]  i_data;
  logic        i_last;
  logic        i_valid;
  logic        i_ready = 1'b1;

  logic [23:0] t2_data = '0;
  logic [1:0]  t2_cnt = '0;
  logic        t2_last = 1'b0;
  logic        t2_valid = 1'b0;
  logic        t2_ready;
  logic [7:0]  i2_data;
  logic        i2_last;
  logic        i2_valid;
  logic        i2_ready = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int prev_cyc = 0;
  bit have_prev = 0;
  bit gapchk = 0;
  logic [8:0] q[$];

  eb_downsizer #(.DWIDTH(32), .RATIO(4)) dut (
    .clk(clk), .rstf(rstf), .t_data(t_data), .t_cnt(t_cnt), .t_last(t_last),
    .t_valid(t_valid), .t_ready(t_ready), .i_data(i_data), .i_last(i_last),
    .i_valid(i_valid), .i_ready(i_ready)
  );

  eb_downsizer #(.DWIDTH(24), .RATIO(3)) dut3 (
    .clk(clk), .rstf(rstf), .t_data(t2_data), .t_cnt(t2_cnt), .t_last(t2_last),
    .t_valid(t2_valid), .t_ready(t2_ready), .i_data(i2_data), .i_last(i2_last),
    .i_valid(i2_valid), .i_ready(i2_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every downstream transfer must match the queue head.
  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (rstf && i_valid && i_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 64'(i_data), 64'h1ff);
      end else begin
        e = q.pop_front();
        chk("beat_data", 64'(i_data), 64'(e[7:0]));
        chk("beat_last", 64'(i_last), 64'(e[8]));
      end
      if (gapchk && have_prev) chk("beat_gap", 64'(cyc - prev_cyc), 64'd1);
      prev_cyc = cyc;
      have_prev = 1;
    end
    if (!gapchk) have_prev = 0;
  end

  task automatic send(input logic [31:0] d, input logic [1:0] c, input logic l);
    bit ok;
    t_data = d; t_cnt = c; t_last = l; t_valid = 1'b1;
    for (int k = 0; k <= int'(c); k++) q.push_back({(l && k == int'(c)), d[k*8 +: 8]});
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (t_ready) ok = 1;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0) ok = 1;
    end
    if (!ok) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] exp3 [3];
    int idx;

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(i_valid), 64'd0);
    chk("rst_last", 64'(i_last), 64'd0);
    chk("rst_data", 64'(i_data), 64'd0);
    chk("rst_tready", 64'(t_ready), 64'd1);
    rstf = 1'b1;
    @(posedge clk); #1;

    // Full word: beat order, last and t_ready only on final beat, latency 1
    send(32'hDDCCBBAA, 2'd3, 1'b1);
    t_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("full_valid", 64'(i_valid), 64'd1);
      chk("full_tready", 64'(t_ready), 64'(j == 3));
      chk("full_last", 64'(i_last), 64'(j == 3));
    end
    @(negedge clk);
    chk("full_idle", 64'(i_valid), 64'd0);
    drain();

    // Back-to-back words, no bubble across the word boundary
    gapchk = 1;
    send(32'h44332211, 2'd3, 1'b0);
    send(32'h88776655, 2'd3, 1'b1);
    t_valid = 1'b0;
    drain();
    gapchk = 0;

    // Partial word of two beats
    send(32'h44332211, 2'd1, 1'b1);
    t_valid = 1'b0;
    @(negedge clk);
    chk("part_b0", 64'(i_data), 64'h11);
    chk("part_b0_tready", 64'(t_ready), 64'd0);
    @(negedge clk);
    chk("part_b1", 64'(i_data), 64'h22);
    chk("part_b1_last", 64'(i_last), 64'd1);
    chk("part_b1_tready", 64'(t_ready), 64'd1);
    @(negedge clk);
    chk("part_idle", 64'(i_valid), 64'd0);
    drain();

    // Downstream stall while 0xBB is presented
    send(32'hDDCCBBAA, 2'd3, 1'b1);
    send(32'h0, 2'd0, 1'b0);
    t_valid = 1'b0;
    drain();
    send(32'hDDCCBBAA, 2'd3, 1'b1);
    t_data = 32'h12345678; t_cnt = 2'd0; t_last = 1'b1;
    t_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    i_ready = 1'b0;
    t_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stall_data", 64'(i_data), 64'hBB);
      chk("stall_valid", 64'(i_valid), 64'd1);
      chk("stall_tready", 64'(t_ready), 64'd0);
    end
    @(posedge clk); #1;
    t_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 64'(i_data), 64'hBB);
    @(negedge clk);
    chk("stall_next", 64'(i_data), 64'hCC);
    drain();

    // Reset mid-word
    send(32'hDDCCBBAA, 2'd3, 1'b1);
    t_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_data", 64'(i_data), 64'hCC);
    rstf = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", 64'(i_valid), 64'd0);
    chk("mid_rst_last", 64'(i_last), 64'd0);
    chk("mid_rst_tready", 64'(t_ready), 64'd1);
    repeat (2) @(negedge clk);
    rstf = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", 64'(t_ready), 64'd1);
    chk("post_rst_valid", 64'(i_valid), 64'd0);
    @(posedge clk); #1;
    send(32'h04030201, 2'd3, 1'b1);
    t_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_first", 64'(i_data), 64'h01);
    drain();

    // Clamp on the 24/3 instance: t_cnt=3 must yield exactly three beats
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
    t2_data = 24'h332211; t2_cnt = 2'd3; t2_last = 1'b1; t2_valid = 1'b1;
    @(negedge clk);
    chk("clamp_tready", 64'(t2_ready), 64'd1);
    @(posedge clk); #1;
    t2_valid = 1'b0;
    idx = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (i2_valid) begin
        if (idx < 3) begin
          chk("clamp_data", 64'(i2_data), 64'(exp3[idx]));
          chk("clamp_last", 64'(i2_last), 64'(idx == 2));
        end
        idx++;
      end
    end
    chk("clamp_count", 64'(idx), 64'd3);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/eb_downsizer.md
EB_DOWNSIZER -- requirements
Module: eb_downsizer

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning input word width in bits.
REQ-002 SHALL have parameter RATIO, default 4, meaning output beats per input word; DWIDTH SHALL be an integer multiple of RATIO; OW = DWIDTH/RATIO; CW = max(1, clog2(RATIO)).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rstf  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port t_data  input  DWIDTH  wide word from upstream elastic stage.
REQ-006 SHALL have port t_cnt  input  CW  index of the last valid beat in t_data (0 = one beat).
REQ-007 SHALL have port t_last  input  1  word ends a packet.
REQ-008 SHALL have port t_valid  input  1  upstream word valid.
REQ-009 SHALL have port t_ready  output  1  block accepts t_data this cycle.
REQ-010 SHALL have port i_data  output  OW  current narrow beat.
REQ-011 SHALL have port i_last  output  1  current beat is final beat of a packet.
REQ-012 SHALL have port i_valid  output  1  i_data valid.
REQ-013 SHALL have port i_ready  input  1  downstream accepts beat.

Function
REQ-014 SHALL hold one word: registers hold[DWIDTH], n[CW], lst, beat counter b[CW], occupied flag (states EMPTY / BUSY).
REQ-015 SHALL accept a word when t_valid & t_ready: hold<=t_data, n<=min(t_cnt, RATIO-1), lst<=t_last, b<=0, occupied<=1.
REQ-016 SHALL drive i_data = hold[b*OW +: OW]; beat 0 = least-significant OW bits.
REQ-017 SHALL drive i_valid = occupied; i_last = occupied & lst & (b==n).
REQ-018 SHALL, on beat transfer (i_valid & i_ready) with b<n, increment b by 1.
REQ-019 SHALL, on beat transfer with b==n and no simultaneous accept, clear occupied (BUSY->EMPTY).
REQ-020 SHALL, on beat transfer with b==n and simultaneous accept, load the new word per REQ-015 with no idle cycle.
REQ-021 SHALL drive t_ready = ~occupied | (i_ready & (b==n)); combinational path from i_ready to t_ready is permitted.
REQ-022 SHALL present the first beat of an accepted word in the cycle after acceptance (latency 1).
REQ-023 SHALL sustain one beat per cycle while i_ready=1 and words are available; a word with n+1 beats occupies exactly n+1 output cycles.
REQ-024 SHALL keep i_data, i_last, i_valid stable while i_valid=1 and i_ready=0; i_valid SHALL not drop before transfer.
REQ-025 SHALL clamp t_cnt values above RATIO-1 to RATIO-1 (non-power-of-two RATIO).
REQ-026 SHALL, for RATIO=1, behave as a one-entry register slice; t_cnt ignored, i_last = lst.
REQ-027 SHALL ignore t_data/t_cnt/t_last when t_valid=0; beats beyond n SHALL never be emitted.

Reset
REQ-028 SHALL, while rstf=0, force occupied=0, b=0, n=0, lst=0, hold=0; hence i_valid=0, i_last=0, i_data=0, t_ready=1.
REQ-029 SHALL, on reset mid-word, discard remaining beats; first word after release starts at beat 0.

Verification
REQ-030 DWIDTH=32,RATIO=4: t_data=0xDDCCBBAA,t_cnt=3,t_last=1, i_ready=1 -> i_data 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles starting 1 cycle after accept; i_last only with 0xDD; t_ready=1 only in 0xDD cycle.
REQ-031 Back-to-back: words 0x44332211 and 0x88776655, t_cnt=3, t_valid held, i_ready=1 -> 8 beats 0x11..0x88 in 8 consecutive cycles, no bubble.
REQ-032 Partial: t_data=0x44332211,t_cnt=1,t_last=1 -> beats 0x11,0x22 only; i_last with 0x22; t_ready=1 in 0x22 cycle.
REQ-033 Stall: i_ready=0 for 3 cycles while beat 0xBB presented -> i_data=0xBB, i_valid=1, t_ready=0 throughout; 0xCC follows cycle after i_ready returns.
REQ-034 Reset: rstf=0 while beat 0xCC presented -> i_valid=0 immediately; after release t_ready=1; next word 0x0403_0201 emits 0x01 first.
REQ-035 Clamp: DWIDTH=24,RATIO=3,t_cnt=3,t_data=0x332211 -> exactly 3 beats 0x11,0x22,0x33.
